// File: rtl/median_io_ctrl_pkg.sv
// median_io_ctrl_pkg: shared widths, result count and state encoding for the MEDIAN frame path
package median_io_ctrl_pkg;
  localparam int A_WIDTH = 8;
  localparam int D_WIDTH = 8;
  localparam int R_WIDTH = 3;
  localparam int N_RES = 2 ** (A_WIDTH - R_WIDTH);
  typedef enum logic [3:0] {IDLE, LOAD, GO, WAIT, RD_ISSUE, RD_WAIT, RD_CAP, SEND, FIN} state_t;
endpackage

// File: rtl/median_io_ctrl.sv
// median_io_ctrl: loads a frame into sample memory A, kicks MEDIAN, then streams the result memory out
module median_io_ctrl import median_io_ctrl_pkg::*; #(
  parameter int A_WIDTH = median_io_ctrl_pkg::A_WIDTH,
  parameter int D_WIDTH = median_io_ctrl_pkg::D_WIDTH,
  parameter int R_WIDTH = median_io_ctrl_pkg::R_WIDTH,
  localparam int J_WIDTH = A_WIDTH - R_WIDTH
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Start,
  input  logic               In_Valid,
  output logic               In_Ready,
  input  logic [D_WIDTH-1:0] In_Data,
  output logic [A_WIDTH-1:0] A_Addr,
  output logic [D_WIDTH-1:0] A_WData,
  output logic               A_RW,
  output logic               A_EN,
  output logic               Go,
  input  logic               Done,
  output logic [J_WIDTH-1:0] Out_Addr,
  output logic               Out_RW,
  output logic               Out_EN,
  input  logic [D_WIDTH-1:0] Out_Data,
  output logic               Res_Valid,
  input  logic               Res_Ready,
  output logic [D_WIDTH-1:0] Res_Data,
  output logic               Busy,
  output logic               Frame_Done
);
  state_t state, state_n;
  logic [A_WIDTH-1:0] cnt, cnt_n, a_addr_n;
  logic [J_WIDTH-1:0] j, j_n, out_addr_n;
  logic [D_WIDTH-1:0] a_wdata_n, res_data_n;
  logic a_wr_n, go_n, out_en_n, res_valid_n, fd_n;
  assign Out_RW = 1'b0;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    j_n = j;
    a_addr_n = A_Addr;
    a_wdata_n = A_WData;
    a_wr_n = 1'b0;
    go_n = 1'b0;
    out_en_n = 1'b0;
    out_addr_n = Out_Addr;
    res_valid_n = Res_Valid;
    res_data_n = Res_Data;
    fd_n = 1'b0;
    case (state)
      IDLE: if (Start) begin
        state_n = LOAD;
        cnt_n = '0;
        j_n = '0;
      end
      LOAD: if (In_Valid && In_Ready) begin
        a_wr_n = 1'b1;
        a_addr_n = cnt;
        a_wdata_n = In_Data;
        cnt_n = cnt + 1'b1;
        state_n = &cnt ? GO : LOAD;
      end
      GO: begin
        go_n = 1'b1;
        state_n = WAIT;
      end
      WAIT: state_n = Done ? RD_ISSUE : WAIT;
      RD_ISSUE: begin
        out_en_n = 1'b1;
        out_addr_n = j;
        state_n = RD_WAIT;
      end
      RD_WAIT: state_n = RD_CAP;
      RD_CAP: begin
        res_data_n = Out_Data;
        res_valid_n = 1'b1;
        state_n = SEND;
      end
      SEND: if (Res_Ready) begin
        res_valid_n = 1'b0;
        j_n = j + 1'b1;
        fd_n = &j;
        state_n = &j ? FIN : RD_ISSUE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt <= '0;
      j <= '0;
      In_Ready <= 1'b0;
      A_Addr <= '0;
      A_WData <= '0;
      A_RW <= 1'b0;
      A_EN <= 1'b0;
      Go <= 1'b0;
      Out_Addr <= '0;
      Out_EN <= 1'b0;
      Res_Valid <= 1'b0;
      Res_Data <= '0;
      Busy <= 1'b0;
      Frame_Done <= 1'b0;
    end else begin
      cnt <= cnt_n;
      j <= j_n;
      In_Ready <= state_n == LOAD;
      A_Addr <= a_addr_n;
      A_WData <= a_wdata_n;
      A_RW <= a_wr_n;
      A_EN <= a_wr_n;
      Go <= go_n;
      Out_Addr <= out_addr_n;
      Out_EN <= out_en_n;
      Res_Valid <= res_valid_n;
      Res_Data <= res_data_n;
      Busy <= state_n != IDLE;
      Frame_Done <= fd_n;
    end
  end
endmodule

// File: tb/tb_median_io_ctrl.sv
// tb_median_io_ctrl: frame-level bench with memory and MEDIAN models around median_io_ctrl
module tb_median_io_ctrl;
  import median_io_ctrl_pkg::*;
  localparam int FRAME = 2 ** A_WIDTH;
  localparam int WIN = 2 ** R_WIDTH;
  localparam int BUDGET = 6000;
  logic Clk = 0, Rst = 1, Start = 0, In_Valid = 0, Done = 0, Res_Ready = 0;
  logic In_Ready, A_RW, A_EN, Go, Out_RW, Out_EN, Res_Valid, Busy, Frame_Done;
  logic [D_WIDTH-1:0] In_Data = 0, Out_Data = 0, A_WData, Res_Data;
  logic [A_WIDTH-1:0] A_Addr;
  logic [A_WIDTH-R_WIDTH-1:0] Out_Addr;
  typedef struct {int pat; int vmode; int rmode; int stall; int spur; int abort_at; int exp_first; int exp_last;} vec_t;
  vec_t vecs[$];
  logic [D_WIDTH-1:0] frame_in[FRAME], a_mem[FRAME], res_mem[N_RES];
  int n_cmp = 0, n_bad = 0;
  median_io_ctrl dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Data(In_Data),
    .A_Addr(A_Addr), .A_WData(A_WData), .A_RW(A_RW), .A_EN(A_EN), .Go(Go), .Done(Done),
    .Out_Addr(Out_Addr), .Out_RW(Out_RW), .Out_EN(Out_EN), .Out_Data(Out_Data),
    .Res_Valid(Res_Valid), .Res_Ready(Res_Ready), .Res_Data(Res_Data), .Busy(Busy), .Frame_Done(Frame_Done)
  );
  always #5 Clk = ~Clk;
  function automatic void chk(string name, int got, int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endfunction
  function automatic int win_median(input bit from_mem, input int k);
    int w[$];
    for (int i = 0; i < WIN; i++) w.push_back(int'(from_mem ? a_mem[k*WIN+i] : frame_in[k*WIN+i]));
    w.sort();
    return (w[WIN/2-1] + w[WIN/2]) / 2;
  endfunction
  function automatic int outs_ones();
    return $countones({In_Ready, A_Addr, A_WData, A_RW, A_EN, Go, Out_Addr, Out_RW, Out_EN,
                       Res_Valid, Res_Data, Busy, Frame_Done});
  endfunction
  task automatic step();
    @(posedge Clk);
    #1;
  endtask
  task automatic run_frame(input vec_t v);
    int idx = 0, wr_cnt = 0, rd_cnt = 0, go_n = 0, fd_n = 0, mdelay = 0, stall_left = -1;
    int go_cyc = -1, last_wr_cyc = -1, first_acc = -1, done_cyc = -1, hs_cyc = -1, fd_cyc = -1;
    int stab_err = 0, misc_err = 0, got_first = -1, got_last = -1;
    int exp_r[N_RES];
    bit fin = 0, pend_rd = 0, prev_v = 0, prev_hs = 0;
    logic [A_WIDTH-R_WIDTH-1:0] pend_addr = '0;
    logic [D_WIDTH-1:0] prev_d = '0;
    for (int i = 0; i < FRAME; i++)
      frame_in[i] = v.pat == 0 ? D_WIDTH'(i) : v.pat == 1 ? '1 : v.pat == 2 ? D_WIDTH'(FRAME-1-i) :
                    v.pat == 3 ? (i[0] ? '1 : '0) : D_WIDTH'($urandom_range(0, 255));
    for (int k = 0; k < N_RES; k++) exp_r[k] = win_median(0, k);
    Start = 1;
    step();
    Start = 0;
    chk("busy_in_load", Busy, 1);
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      if (v.abort_at >= 0 && rd_cnt == v.abort_at + 1) begin
        Rst = 0;
        #1;
        chk("abort_outputs_zero_bits", outs_ones(), 0);
        step();
        chk("abort_busy", Busy, 0);
        Rst = 1;
        chk("abort_go_count", go_n, 1);
        return;
      end
      Out_Data = pend_rd ? res_mem[pend_addr] : D_WIDTH'($urandom);
      pend_rd = Out_EN;
      pend_addr = Out_Addr;
      if (A_EN) begin
        chk("write_addr", int'(A_Addr), wr_cnt);
        if (wr_cnt < FRAME) chk("write_data", int'(A_WData), int'(frame_in[wr_cnt]));
        a_mem[A_Addr] = A_WData;
        wr_cnt++;
        last_wr_cyc = cyc;
      end
      if ((Res_Valid && Out_EN) || Out_RW || (A_EN && !A_RW) || (A_EN && go_n > 0)) misc_err++;
      if (Go) begin
        go_n++;
        go_cyc = cyc;
        mdelay = v.spur != 0 ? 10 : int'($urandom_range(3, 12));
      end
      Done = 0;
      Start = 0;
      if (mdelay > 0) begin
        mdelay--;
        if (mdelay == 0) begin
          for (int k = 0; k < N_RES; k++) res_mem[k] = D_WIDTH'(win_median(1, k));
          Done = 1;
          done_cyc = cyc;
        end
      end
      if (v.spur != 0 && idx == 100 && go_n == 0) Done = 1;
      if (v.spur != 0 && go_n > 0 && cyc == go_cyc + 2) Start = 1;
      if (prev_v && !prev_hs && (!Res_Valid || Res_Data !== prev_d)) stab_err++;
      In_Valid = v.vmode == 0 ? 1'b1 : v.vmode == 1 ? cyc[0] : 1'($urandom_range(0, 1));
      In_Data = idx < FRAME ? frame_in[idx] : D_WIDTH'($urandom);
      if (In_Valid && In_Ready) begin
        if (idx == 0) first_acc = cyc;
        idx++;
      end
      Res_Ready = v.rmode == 0 ? 1'b1 : 1'($urandom_range(0, 1));
      if (v.stall == rd_cnt && Res_Valid) begin
        if (stall_left < 0) stall_left = 5;
        if (stall_left > 0) begin
          Res_Ready = 0;
          stall_left--;
        end
      end
      if (Res_Valid && Res_Ready) begin
        if (rd_cnt < N_RES) chk("result", int'(Res_Data), exp_r[rd_cnt]);
        else chk("extra_result_index", rd_cnt, N_RES - 1);
        if (rd_cnt == 0) got_first = int'(Res_Data);
        if (rd_cnt == N_RES - 1) got_last = int'(Res_Data);
        rd_cnt++;
        hs_cyc = cyc;
      end
      prev_v = Res_Valid;
      prev_hs = Res_Valid && Res_Ready;
      prev_d = Res_Data;
      if (Frame_Done) begin
        fd_n++;
        fd_cyc = cyc;
      end
      if (fd_n > 0 && cyc == fd_cyc + 1) begin
        chk("busy_after_fin", Busy, 0);
        fin = 1;
      end
      if (fin) break;
      step();
    end
    Done = 0;
    In_Valid = 0;
    Res_Ready = 0;
    chk("frame_finished", fin, 1);
    chk("write_count", wr_cnt, FRAME);
    chk("go_count", go_n, 1);
    chk("go_after_last_write", go_cyc - last_wr_cyc, 1);
    chk("result_count", rd_cnt, N_RES);
    chk("frame_done_count", fd_n, 1);
    chk("frame_done_latency", fd_cyc - hs_cyc, 1);
    chk("res_stable_errors", stab_err, 0);
    chk("strobe_errors", misc_err, 0);
    if (v.exp_first >= 0) chk("first_result", got_first, v.exp_first);
    if (v.exp_last >= 0) chk("last_result", got_last, v.exp_last);
    if (v.vmode == 0) chk("load_span", last_wr_cyc - first_acc, FRAME);
    if (v.rmode == 0 && v.stall < 0) chk("read_span", fd_cyc - done_cyc, 4 * N_RES + 1);
  endtask
  initial begin
    int idle_wr = 0;
    vecs.push_back('{0, 0, 0, -1, 0, -1, 3, 251});
    vecs.push_back('{0, 1, 0, -1, 0, -1, 3, 251});
    vecs.push_back('{0, 0, 0, 7, 0, -1, 3, 251});
    vecs.push_back('{0, 0, 0, -1, 1, -1, 3, 251});
    vecs.push_back('{0, 0, 0, -1, 0, 10, 3, -1});
    vecs.push_back('{0, 0, 0, -1, 0, -1, 3, 251});
    vecs.push_back('{1, 2, 1, -1, 0, -1, 255, 255});
    vecs.push_back('{2, 0, 1, -1, 0, -1, 251, 3});
    vecs.push_back('{3, 2, 0, -1, 0, -1, 127, 127});
    vecs.push_back('{4, 2, 1, -1, 0, -1, -1, -1});
    vecs.push_back('{4, 0, 1, 7, 0, -1, -1, -1});
    vecs.push_back('{4, 1, 0, -1, 1, -1, -1, -1});
    #2 Rst = 0;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_outputs_zero_bits", outs_ones(), 0);
    Rst = 1;
    In_Valid = 1;
    Done = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (A_EN || In_Ready || Busy || Go) idle_wr++;
    end
    In_Valid = 0;
    Done = 0;
    chk("idle_ignores_inputs", idle_wr, 0);
    foreach (vecs[i]) run_frame(vecs[i]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
